// File: rtl/frame_stack_pkg.sv
// Shared constants, op encoding and request decode for the frame stack.
// The decode collapses {push,pop,empty,full} into the single action taken this cycle.
package frame_stack_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  // push&pop on an empty stack degrades to a plain push; the pop half is an underflow.
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic empty, input logic full);
    op_e op;
    op = OP_IDLE;
    if (push && pop)      op = empty ? OP_PUSH : OP_REPLACE;
    else if (push)        op = full ? OP_IDLE : OP_PUSH;
    else if (pop)         op = empty ? OP_IDLE : OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/frame_stack_if.sv
// Push/pop request bus between a client (master) and the frame stack (slave).
// No back-pressure: the client watches full/empty on the stack's status ports.
interface frame_stack_if #(
  parameter int WIDTH = 8
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;

  modport master (output push, output pop, output push_data,
                  input  pop_data, input pop_valid);
  modport slave  (input  push, input pop, input push_data,
                  output pop_data, output pop_valid);
endinterface

// File: rtl/frame_stack_mem.sv
// stack_mem: frame storage, one synchronous write port and one asynchronous read port.
// Latency: write lands on the clock edge, read is combinational; no back-pressure.
// Contents are deliberately not reset; the top-level never exposes an unwritten entry.
module stack_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_stack.sv
// frame_stack: LIFO of frame words with registered top, sticky ovf/unf and optional peak (FRAME_STACK_PEAK_EN).
// Latency: push/pop take effect on the sampling edge; pop_data/pop_valid appear one cycle after pop.
// Backpressure: none; full drops pushes (ovf), empty ignores pops (unf).
module frame_stack
  import frame_stack_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  frame_stack_if.slave     bus,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
`ifdef FRAME_STACK_PEAK_EN
  ,
  output logic [CW-1:0]    peak
`endif
);

  op_e              op;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [WIDTH-1:0] top_q, pop_data_q, below, rdata;
  logic             pop_valid_q, ovf_q, unf_q;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic             ovf_set, unf_set;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign op    = decode_op(bus.push, bus.pop, empty, full);

  assign ovf_set = bus.push & ~bus.pop & full;
  assign unf_set = bus.pop & empty;

  always_comb begin
    cnt_nxt = cnt_q;
    we      = 1'b0;
    waddr   = cnt_q[AW-1:0];
    case (op)
      OP_PUSH: begin
        we      = 1'b1;
        cnt_nxt = cnt_q + CW'(1);
      end
      OP_POP: cnt_nxt = cnt_q - CW'(1);
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = cnt_q[AW-1:0] - AW'(1);
      end
      default: ;
    endcase
  end

  // Entry below the top; wraps correctly when full because only the low AW bits are used.
  assign raddr = cnt_q[AW-1:0] - AW'(2);
  assign below = (cnt_q >= CW'(2)) ? rdata : '0;

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.push_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      top_q       <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_nxt;
      pop_valid_q <= (op == OP_POP) || (op == OP_REPLACE);
      if ((op == OP_POP) || (op == OP_REPLACE)) pop_data_q <= top_q;
      if ((op == OP_PUSH) || (op == OP_REPLACE)) top_q <= bus.push_data;
      else if (op == OP_POP)                     top_q <= below;
      // A new error in the same cycle as clr_err keeps the flag set.
      ovf_q <= ovf_set | (ovf_q & ~clr_err);
      unf_q <= unf_set | (unf_q & ~clr_err);
    end
  end

`ifdef FRAME_STACK_PEAK_EN
  logic [CW-1:0] peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                peak_q <= '0;
    else if (cnt_nxt > peak_q) peak_q <= cnt_nxt;
  end

  assign peak = peak_q;
`endif

  assign count         = cnt_q;
  assign top           = top_q;
  assign ovf           = ovf_q;
  assign unf           = unf_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;

endmodule

// File: tb/tb_frame_stack.sv
// Directed bench for frame_stack (WIDTH=8, DEPTH=16); peak checks only with FRAME_STACK_PEAK_EN.
module tb_frame_stack;

  logic       clk;
  logic       rst_n;
  logic       clr_err;
  logic [7:0] top;
  logic [4:0] count;
  logic       empty, full, ovf, unf;
`ifdef FRAME_STACK_PEAK_EN
  logic [4:0] peak;
`endif

  int vectors;
  int miscompares;

  frame_stack_if #(.WIDTH(8)) bus ();

  frame_stack #(.WIDTH(8), .DEPTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_err (clr_err),
    .top     (top),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf),
    .unf     (unf)
`ifdef FRAME_STACK_PEAK_EN
    ,
    .peak    (peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic pu, input logic po, input logic [7:0] d);
    bus.push      = pu;
    bus.pop       = po;
    bus.push_data = d;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clr_err     = 1'b0;
    drive(1'b0, 1'b0, 8'h00);

    #3;
    chk("rst_count",     32'(count), 32'd0);
    chk("rst_top",       32'(top), 32'h0);
    chk("rst_empty",     32'(empty), 32'd1);
    chk("rst_full",      32'(full), 32'd0);
    chk("rst_pop_data",  32'(bus.pop_data), 32'h0);
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_ovf",       32'(ovf), 32'd0);
    chk("rst_unf",       32'(unf), 32'd0);
    #9;
    rst_n = 1'b1;

    // Push 05, 03, 08 back to back
    drive(1'b1, 1'b0, 8'h05); tick();
    chk("push1_count", 32'(count), 32'd1);
    chk("push1_top",   32'(top), 32'h05);
    drive(1'b1, 1'b0, 8'h03); tick();
    drive(1'b1, 1'b0, 8'h08); tick();
    chk("push3_count", 32'(count), 32'd3);
    chk("push3_top",   32'(top), 32'h08);
    chk("push3_empty", 32'(empty), 32'd0);

    // Pop three in a row
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("pop1_valid", 32'(bus.pop_valid), 32'd1);
    chk("pop1_data",  32'(bus.pop_data), 32'h08);
    chk("pop1_top",   32'(top), 32'h03);
    tick();
    chk("pop2_valid", 32'(bus.pop_valid), 32'd1);
    chk("pop2_data",  32'(bus.pop_data), 32'h03);
    chk("pop2_top",   32'(top), 32'h05);
    tick();
    chk("pop3_valid", 32'(bus.pop_valid), 32'd1);
    chk("pop3_data",  32'(bus.pop_data), 32'h05);
    chk("pop3_empty", 32'(empty), 32'd1);
    chk("pop3_top",   32'(top), 32'h0);
    drive(1'b0, 1'b0, 8'h00); tick();
    chk("idle_valid", 32'(bus.pop_valid), 32'd0);
    chk("idle_hold",  32'(bus.pop_data), 32'h05);

    // Fill with 0x10..0x1F, then one extra push that must be dropped
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i)); tick();
    end
    chk("fill_full",  32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovf",   32'(ovf), 32'd0);
    drive(1'b1, 1'b0, 8'hAA); tick();
    chk("ovf_set",   32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_top",   32'(top), 32'h1F);
    drive(1'b0, 1'b0, 8'h00);
    clr_err = 1'b1; tick();
    chk("ovf_clr", 32'(ovf), 32'd0);
    drive(1'b1, 1'b0, 8'hBB); tick();
    chk("ovf_err_wins", 32'(ovf), 32'd1);
    drive(1'b0, 1'b0, 8'h00); tick();
    chk("ovf_clr2", 32'(ovf), 32'd0);
    clr_err = 1'b0;

    // Replace while full
    drive(1'b1, 1'b1, 8'h77); tick();
    chk("rep_full_data",  32'(bus.pop_data), 32'h1F);
    chk("rep_full_valid", 32'(bus.pop_valid), 32'd1);
    chk("rep_full_top",   32'(top), 32'h77);
    chk("rep_full_count", 32'(count), 32'd16);
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("pop_after_rep", 32'(bus.pop_data), 32'h77);
    chk("below_after_rep", 32'(top), 32'h1E);

    // Asynchronous reset back to empty
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b0; #1;
    chk("arst_count", 32'(count), 32'd0);
    rst_n = 1'b1;

    // Replace on {01,02}, then push&pop on empty
    drive(1'b1, 1'b0, 8'h01); tick();
    drive(1'b1, 1'b0, 8'h02); tick();
    drive(1'b1, 1'b1, 8'h09); tick();
    chk("rep_data",  32'(bus.pop_data), 32'h02);
    chk("rep_top",   32'(top), 32'h09);
    chk("rep_count", 32'(count), 32'd2);
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("rep_pop1", 32'(bus.pop_data), 32'h09);
    chk("rep_pop1_top", 32'(top), 32'h01);
    tick();
    chk("rep_pop2", 32'(bus.pop_data), 32'h01);
    drive(1'b1, 1'b1, 8'h09); tick();
    chk("pp_empty_count", 32'(count), 32'd1);
    chk("pp_empty_unf",   32'(unf), 32'd1);
    chk("pp_empty_valid", 32'(bus.pop_valid), 32'd0);
    chk("pp_empty_top",   32'(top), 32'h09);
    drive(1'b0, 1'b0, 8'h00);
    clr_err = 1'b1; tick();
    chk("unf_clr", 32'(unf), 32'd0);
    clr_err = 1'b0;

    // Reset pulse in the middle of a push burst at count=5
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + i)); tick();
    end
    chk("burst_count", 32'(count), 32'd5);
    rst_n = 1'b0; #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_top",   32'(top), 32'h0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_pdata", 32'(bus.pop_data), 32'h0);
    chk("mid_rst_unf",   32'(unf), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("post_rst_unf",   32'(unf), 32'd1);
    chk("post_rst_valid", 32'(bus.pop_valid), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    drive(1'b0, 1'b0, 8'h00);

`ifdef FRAME_STACK_PEAK_EN
    rst_n = 1'b0; #1;
    chk("peak_rst", 32'(peak), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 8'(i + 1)); tick();
    end
    drive(1'b0, 1'b1, 8'h00);
    repeat (4) tick();
    drive(1'b1, 1'b0, 8'h60);
    repeat (2) tick();
    drive(1'b0, 1'b0, 8'h00);
    chk("peak_val",   32'(peak), 32'd6);
    chk("peak_count", 32'(count), 32'd4);
    clr_err = 1'b1; tick();
    clr_err = 1'b0;
    chk("peak_keep", 32'(peak), 32'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_stack.md
FRAME_STACK -- requirements
Module: frame_stack

Interface
REQ-001 Parameter WIDTH, 8, bit width of each stored frame word (operand / return-address word).
REQ-002 Parameter DEPTH, 16, number of stack entries; power of two, minimum 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 push  input  1  push request, one word per cycle while high.
REQ-006 pop  input  1  pop request, one word per cycle while high.
REQ-007 push_data  input  WIDTH  word written on accepted push.
REQ-008 clr_err  input  1  synchronous clear of sticky error flags.
REQ-009 pop_data  output  WIDTH  word removed by the last accepted pop.
REQ-010 pop_valid  output  1  one-cycle pulse, pop_data updated this cycle.
REQ-011 top  output  WIDTH  current top-of-stack word, registered; 0 when empty.
REQ-012 count  output  log2(DEPTH)+1  current number of stored words.
REQ-013 empty / full  output  1 each  count==0 / count==DEPTH.
REQ-014 ovf / unf  output  1 each  sticky overflow / underflow flags.
REQ-015 peak  output  log2(DEPTH)+1  high-water mark of count (present only with FRAME_STACK_PEAK_EN).

Function
REQ-016 Accepted push (push & ~full, no pop) SHALL write push_data at index count, increment count, update top to push_data, all on the same edge.
REQ-017 Accepted pop (pop & ~empty, no push) SHALL decrement count, load pop_data with old top, pulse pop_valid for exactly the next cycle, and load top with the entry below (0 if the stack becomes empty).
REQ-018 Pop latency SHALL be one cycle: pop sampled at edge N -> pop_valid high and pop_data valid after edge N.
REQ-019 push & pop with ~empty (including full) SHALL replace the top entry: pop_data = old top, pop_valid pulses, top = push_data, count unchanged.
REQ-020 push & pop with empty SHALL accept the push only, set unf, and leave pop_valid low.
REQ-021 Push with full and no pop SHALL be dropped with storage and count unchanged, and SHALL set ovf.
REQ-022 Pop with empty and no push SHALL be ignored, set unf, and leave pop_valid low.
REQ-023 ovf/unf SHALL remain set until clr_err; if clr_err coincides with a new error, the error wins (flag stays set).
REQ-024 Back-to-back pushes/pops every cycle SHALL be sustained without bubbles; there is no back-pressure other than full/empty.
REQ-025 pop_data SHALL hold its last value when no pop is accepted.

Reset
REQ-026 rst_n low SHALL immediately clear count, top, pop_data, pop_valid, ovf, unf and peak to 0; empty=1, full=0.
REQ-027 Storage array contents need not be reset; an entry SHALL never be readable before it is written.
REQ-028 Reset asserted mid-burst SHALL abort all in-flight operations; the first request after deassertion sees an empty stack.

Configuration
REQ-029 Macro FRAME_STACK_PEAK_EN defined: peak SHALL track max(count) since reset, updated on the same edge as count, and SHALL not be cleared by clr_err.
REQ-030 Macro FRAME_STACK_PEAK_EN undefined: port peak and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold the default WIDTH/DEPTH constants and an enumerated op type {OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE} decoded from {push,pop,empty,full}.
REQ-032 The storage array SHALL be a separate sub-module stack_mem (single write port, single asynchronous read port indexed by count-1 / count-2).

Verification
REQ-033 Reset, push 0x05,0x03,0x08 on consecutive cycles -> count=3, top=0x08, empty=0.
REQ-034 Then pop 3 cycles -> pop_data 0x08,0x03,0x05 each with a 1-cycle pop_valid, final empty=1, top=0.
REQ-035 Push 17 words with DEPTH=16 -> full after the 16th, 17th dropped, ovf=1, top = 16th word; clr_err -> ovf=0.
REQ-036 Stack holds {0x01,0x02}, push=pop=1 with push_data=0x09 -> pop_data=0x02, top=0x09, count=2; on empty stack same stimulus -> count=1, unf=1, no pop_valid.
REQ-037 rst_n low for 1 ns mid push burst with count=5 -> all outputs 0 asynchronously; a following pop sets unf.
REQ-038 With FRAME_STACK_PEAK_EN: push 6, pop 4, push 2 -> peak=6, count=4.
